multicycle_control: RTL and testbench



---
 rtl/cpu_ctrl_pkg.sv | 30 +++
 rtl/multicycle_control_mem_wait_timer.sv | 30 +++
 rtl/multicycle_control.sv | 148 ++++++++++++++
 tb/tb_multicycle_control.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared constants and state encoding for the
// multi-cycle RV32 subset control unit.
package cpu_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC_R,
    EXEC_I,
    EXEC_MEM,
    EXEC_BR,
    MEM_RD,
    MEM_WR,
    WB_R,
    WB_MEM,
    HALT
  } state_t;

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// Wait-cycle counter for memory handshakes;
// flags when the allowed wait budget is used up.
module mem_wait_timer #(
  parameter int MAX = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam int W = (MAX < 2) ? 1 : $clog2(MAX + 1);
  localparam logic [W-1:0] LIM = W'(MAX);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != LIM) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign timeout = (cnt == LIM);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM: fetch, decode,
// execute, memory and writeback sequencing.
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             zeroFlag,
  input  logic             memReady,
  output logic [1:0]       ALUOp,
  output logic             ALUSrc,
  output logic             memRead,
  output logic             memWrite,
  output logic             memAddrSel,
  output logic             irWrite,
  output logic             regWrite,
  output logic             memToReg,
  output logic             pcWrite,
  output logic             pcSel,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  state_t state;
  logic   in_mem;
  logic   tmo;
  logic   br_ok;
  logic   br_tk;

  assign in_mem = (state == FETCH) ||
                  (state == MEM_RD) ||
                  (state == MEM_WR);

  assign br_ok = (funct3 == 3'b000) ||
                 (funct3 == 3'b001);
  assign br_tk = (funct3 == 3'b000 && zeroFlag) ||
                 (funct3 == 3'b001 && !zeroFlag);

  // completing access leaves the state, so clear on ready
  mem_wait_timer #(
    .MAX(MEM_TIMEOUT)
  ) u_tmr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (!in_mem || memReady),
    .en     (in_mem && !memReady),
    .timeout(tmo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      instret <= '0;
    end else begin
      if (pcWrite) instret <= instret + 1'b1;
      case (state)
        IDLE:   state <= FETCH;
        FETCH: begin
          if (memReady)  state <= DECODE;
          else if (tmo)  state <= HALT;
        end
        DECODE: begin
          case (opcode)
            OP_R:      state <= EXEC_R;
            OP_I:      state <= EXEC_I;
            OP_LOAD,
            OP_STORE:  state <= EXEC_MEM;
            OP_BRANCH: state <= EXEC_BR;
            default:   state <= HALT;
          endcase
        end
        EXEC_R, EXEC_I: state <= WB_R;
        EXEC_MEM: begin
          state <= (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
        end
        EXEC_BR: state <= br_ok ? FETCH : HALT;
        MEM_RD: begin
          if (memReady)  state <= WB_MEM;
          else if (tmo)  state <= HALT;
        end
        MEM_WR: begin
          if (memReady)  state <= FETCH;
          else if (tmo)  state <= HALT;
        end
        WB_R, WB_MEM: state <= FETCH;
        default: state <= HALT;
      endcase
    end
  end

  always_comb begin
    ALUOp      = ALUOP_ADD;
    ALUSrc     = 1'b0;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    memAddrSel = 1'b0;
    irWrite    = 1'b0;
    regWrite   = 1'b0;
    memToReg   = 1'b0;
    pcWrite    = 1'b0;
    pcSel      = 1'b0;
    halted     = 1'b0;
    case (state)
      FETCH: begin
        memRead = 1'b1;
        irWrite = memReady;
      end
      EXEC_R: ALUOp = ALUOP_R;
      EXEC_I, EXEC_MEM: ALUSrc = 1'b1;
      EXEC_BR: begin
        ALUOp   = ALUOP_BR;
        pcWrite = br_ok;
        pcSel   = br_tk;
      end
      MEM_RD: begin
        ALUSrc     = 1'b1;
        memRead    = 1'b1;
        memAddrSel = 1'b1;
      end
      MEM_WR: begin
        ALUSrc     = 1'b1;
        memWrite   = 1'b1;
        memAddrSel = 1'b1;
        pcWrite    = memReady;
      end
      WB_R: begin
        // opcode is still the IR's, so it recalls EXEC_R vs EXEC_I
        ALUOp    = (opcode == OP_R) ? ALUOP_R : ALUOP_ADD;
        ALUSrc   = (opcode != OP_R);
        regWrite = 1'b1;
        pcWrite  = 1'b1;
      end
      WB_MEM: begin
        regWrite = 1'b1;
        memToReg = 1'b1;
        pcWrite  = 1'b1;
      end
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed and random
// instructions against an instruction-level model.
module tb_multicycle_control;

  localparam int CW = 4;
  localparam int TO = 4;

  localparam logic [6:0] R_OP  = 7'b0110011;
  localparam logic [6:0] I_OP  = 7'b0010011;
  localparam logic [6:0] LW_OP = 7'b0000011;
  localparam logic [6:0] SW_OP = 7'b0100011;
  localparam logic [6:0] BR_OP = 7'b1100011;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [6:0]    opcode = '0;
  logic [2:0]    funct3 = '0;
  logic          zeroFlag = 1'b0;
  logic          memReady = 1'b0;
  logic [1:0]    ALUOp;
  logic          ALUSrc, memRead, memWrite, memAddrSel;
  logic          irWrite, regWrite, memToReg, pcWrite;
  logic          pcSel, halted;
  logic [CW-1:0] instret;

  int errors = 0;
  int checks = 0;
  int ret = 0;

  multicycle_control #(
    .CNT_W(CW),
    .MEM_TIMEOUT(TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .funct3    (funct3),
    .zeroFlag  (zeroFlag),
    .memReady  (memReady),
    .ALUOp     (ALUOp),
    .ALUSrc    (ALUSrc),
    .memRead   (memRead),
    .memWrite  (memWrite),
    .memAddrSel(memAddrSel),
    .irWrite   (irWrite),
    .regWrite  (regWrite),
    .memToReg  (memToReg),
    .pcWrite   (pcWrite),
    .pcSel     (pcSel),
    .halted    (halted),
    .instret   (instret)
  );

  always #5 clk = ~clk;

  logic [12:0] obs;
  assign obs = {ALUOp, ALUSrc, memRead, memWrite,
                memAddrSel, irWrite, regWrite,
                memToReg, pcWrite, pcSel, halted};

  function automatic logic [12:0] v(
    input logic [1:0] a, input logic s,
    input logic mr, input logic mw,
    input logic mas, input logic irw,
    input logic rw, input logic m2r,
    input logic pcw, input logic pcs,
    input logic h);
    return {a, s, mr, mw, mas, irw, rw, m2r, pcw, pcs, h};
  endfunction

  task automatic chk(input logic [31:0] o,
                     input logic [31:0] e,
                     input string tag);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, o, e);
    end
  endtask

  task automatic cyc(input logic [12:0] e,
                     input string tag);
    @(negedge clk);
    chk(32'(obs), 32'(e), tag);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ret(input string tag);
    logic [CW-1:0] r;
    r = ret[CW-1:0];
    chk(32'(instret), 32'(r), tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk(32'(obs), 32'(0), "reset_outs");
    chk(32'(instret), 32'(0), "reset_instret");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ret = 0;
    memReady = 1'($urandom);
    cyc(13'h0, "idle");
  endtask

  task automatic halt_chk(input int n);
    for (int i = 0; i < n; i++) begin
      memReady = 1'($urandom);
      zeroFlag = 1'($urandom);
      cyc(v(0,0,0,0,0,0,0,0,0,0,1), "halt");
    end
    chk_ret("halt_instret");
  endtask

  // wf/wm: memReady-low cycles before ready in FETCH / memory
  task automatic do_instr(input logic [6:0] op,
                          input logic [2:0] f3,
                          input logic zf,
                          input int wf, input int wm);
    int lo;
    logic tk;
    opcode = 7'($urandom);
    lo = (wf > TO) ? TO + 1 : wf;
    for (int i = 0; i < lo; i++) begin
      memReady = 1'b0;
      cyc(v(0,0,1,0,0,0,0,0,0,0,0), "fetch_wait");
    end
    if (wf > TO) begin
      halt_chk(3);
      return;
    end
    memReady = 1'b1;
    cyc(v(0,0,1,0,0,1,0,0,0,0,0), "fetch");
    opcode = op;
    funct3 = f3;
    memReady = 1'($urandom);
    zeroFlag = 1'($urandom);
    cyc(13'h0, "decode");
    memReady = 1'($urandom);
    if (op == R_OP) begin
      cyc(v(2,0,0,0,0,0,0,0,0,0,0), "exec_r");
      cyc(v(2,0,0,0,0,0,1,0,1,0,0), "wb_r");
      ret++;
    end else if (op == I_OP) begin
      cyc(v(0,1,0,0,0,0,0,0,0,0,0), "exec_i");
      cyc(v(0,1,0,0,0,0,1,0,1,0,0), "wb_i");
      ret++;
    end else if (op == LW_OP || op == SW_OP) begin
      logic ld;
      ld = (op == LW_OP);
      cyc(v(0,1,0,0,0,0,0,0,0,0,0), "exec_mem");
      lo = (wm > TO) ? TO + 1 : wm;
      for (int i = 0; i < lo; i++) begin
        memReady = 1'b0;
        cyc(v(0,1,ld,!ld,1,0,0,0,0,0,0), "mem_wait");
      end
      if (wm > TO) begin
        halt_chk(3);
        return;
      end
      memReady = 1'b1;
      if (ld) begin
        cyc(v(0,1,1,0,1,0,0,0,0,0,0), "mem_rd");
        memReady = 1'($urandom);
        cyc(v(0,0,0,0,0,0,1,1,1,0,0), "wb_mem");
      end else begin
        cyc(v(0,1,0,1,1,0,0,0,1,0,0), "mem_wr");
      end
      ret++;
    end else if (op == BR_OP) begin
      zeroFlag = zf;
      if (f3 == 3'd0 || f3 == 3'd1) begin
        tk = (f3 == 3'd0) ? zf : !zf;
        cyc(v(1,0,0,0,0,0,0,0,1,tk,0), "exec_br");
        ret++;
      end else begin
        cyc(v(1,0,0,0,0,0,0,0,0,0,0), "exec_br_bad");
        halt_chk(3);
        return;
      end
    end else begin
      halt_chk(3);
      return;
    end
    chk_ret("instret");
  endtask

  task automatic rand_instr(input int maxw);
    logic [6:0] ops [5];
    int k;
    ops = '{R_OP, I_OP, LW_OP, SW_OP, BR_OP};
    k = $urandom_range(0, 4);
    do_instr(ops[k], 3'($urandom_range(0, 1)),
             1'($urandom), $urandom_range(0, maxw),
             $urandom_range(0, maxw));
  endtask

  initial begin
    do_reset();

    do_instr(R_OP, 3'd0, 1'b0, 0, 0);
    chk(32'(instret), 32'(1), "add_instret1");

    do_instr(LW_OP, 3'd2, 1'b0, 0, 3);
    do_instr(BR_OP, 3'd0, 1'b1, 0, 0);
    do_instr(BR_OP, 3'd1, 1'b1, 0, 0);
    do_instr(SW_OP, 3'd2, 1'b0, TO, TO);
    do_instr(LW_OP, 3'd2, 1'b0, TO, TO);

    for (int i = 0; i < 40; i++) rand_instr(TO);

    do_reset();
    for (int i = 0; i < 17; i++) rand_instr(2);
    chk(32'(instret), 32'(1), "wrap17");

    do_instr(7'b1111111, 3'd0, 1'b0, 0, 0);
    halt_chk(100);
    do_reset();

    do_instr(I_OP, 3'd0, 1'b0, 0, 0);
    do_instr(BR_OP, 3'd2, 1'b0, 0, 0);
    do_reset();

    do_instr(R_OP, 3'd0, 1'b0, TO + 1, 0);
    do_reset();

    do_instr(LW_OP, 3'd2, 1'b0, 1, TO + 1);
    do_reset();

    do_instr(I_OP, 3'd0, 1'b0, 0, 0);
    do_instr(R_OP, 3'd0, 1'b0, 1, 0);
    memReady = 1'b1;
    cyc(v(0,0,1,0,0,1,0,0,0,0,0), "fetch_sw");
    opcode = SW_OP;
    cyc(13'h0, "decode_sw");
    cyc(v(0,1,0,0,0,0,0,0,0,0,0), "exec_sw");
    memReady = 1'b0;
    @(negedge clk);
    chk(32'(memWrite), 32'(1), "memwr_before_rst");
    do_reset();

    for (int i = 0; i < 10; i++) rand_instr(TO);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
